// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM; port 0 has priority.
// Define ARB_STARVE_GUARD_EN to bound how long port 1 can lose to port 0.
module ram_arbiter #(
    parameter int A         = 12,
    parameter int D         = 8,
    parameter int MAX_STALL = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         rw0,
    input  logic [A-1:0] addr0,
    input  logic [D-1:0] wdata0,
    input  logic         req1,
    input  logic         rw1,
    input  logic [A-1:0] addr1,
    input  logic [D-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [D-1:0] rdata0,
    output logic [D-1:0] rdata1,
    output logic         ram_cs,
    output logic         ram_rw,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_e;

    state_e         state_q, state_d;
    logic           rw_q, rw_d;
    logic [A-1:0]   addr_q, addr_d;
    logic [D-1:0]   wdata_q, wdata_d;
    logic           ret_rd_q, ret_rd_d;
    logic           ret_owner_q, ret_owner_d;
    logic           force1;

    if (MAX_STALL < 1) begin : g_bad_param
        $error("MAX_STALL must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_STALL + 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    assign force1 = (stall_cnt_q == SW'(MAX_STALL));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!req1 || gnt1) begin
            stall_cnt_d = '0;
        end else if (gnt0 && !force1) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign force1 = 1'b0;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt1 = req1 && (!req0 || force1);
            gnt0 = req0 && !gnt1;
        end
    end

    always_comb begin
        state_d     = IDLE;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if (gnt0) begin
            state_d = ACC0;
            rw_d    = rw0;
            addr_d  = addr0;
            wdata_d = wdata0;
        end else if (gnt1) begin
            state_d = ACC1;
            rw_d    = rw1;
            addr_d  = addr1;
            wdata_d = wdata1;
        end
        ret_rd_d    = (state_q != IDLE) && rw_q;
        ret_owner_d = (state_q == ACC1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            ret_rd_q    <= 1'b0;
            ret_owner_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ret_rd_q    <= ret_rd_d;
            ret_owner_q <= ret_owner_d;
        end
    end

    // Gating with reset drops any access that was already registered.
    assign ram_cs    = (state_q != IDLE) && !reset;
    assign ram_rw    = rw_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign rvalid0 = ret_rd_q && !ret_owner_q && !reset;
    assign rvalid1 = ret_rd_q && ret_owner_q && !reset;
    assign rdata0  = ram_rdata;
    assign rdata1  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and
// a sequential reference memory updated in grant order.
module tb_ram_arbiter;
    localparam int A  = 12;
    localparam int D  = 8;
    localparam int MS = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, rw0, req1, rw1;
    logic [A-1:0] addr0, addr1;
    logic [D-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [D-1:0] rdata0, rdata1;
    logic         ram_cs, ram_rw;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_wdata;
    logic [D-1:0] ram_rdata = '0;

    ram_arbiter #(.A(A), .D(D), .MAX_STALL(MS)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rd;
        logic [A-1:0] addr;
        logic [D-1:0] wd;
        bit           port;
    } cmd_t;

    typedef struct {
        int           due;
        logic [D-1:0] data;
    } exp_t;

    logic [D-1:0] ram_mem [0:(1<<A)-1];
    logic [D-1:0] ref_mem [0:(1<<A)-1];
    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   pend_v = 0;
    cmd_t pend;
    int   lost   = 0;
    bit   last_g0 = 0, last_g1 = 0;
    bit   prev_rst = 0;
    int   n_g1_contested = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural single-port RAM: read data valid the cycle after ram_cs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_cs) begin
            if (ram_rw) ram_rdata <= ram_mem[ram_addr];
            else        ram_mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic drive(input bit rst,
                         input bit r0, input bit rd0,
                         input logic [A-1:0] a0, input logic [D-1:0] d0,
                         input bit r1, input bit rd1,
                         input logic [A-1:0] a1, input logic [D-1:0] d1);
        bit force1, eg0, eg1;
        @(posedge clk);
        #1;
        reset = rst;
        req0 = r0; rw0 = rd0; addr0 = a0; wdata0 = d0;
        req1 = r1; rw1 = rd1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        force1 = 0;
`ifdef ARB_STARVE_GUARD_EN
        force1 = (lost >= MS);
`endif
        eg1 = !rst && r1 && (!r0 || force1);
        eg0 = !rst && r0 && !eg1;
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        if (eg1 && r0) n_g1_contested++;
        if (pend_v && !rst) begin
            chk("ram_cs", ram_cs, 1);
            chk("ram_rw", ram_rw, pend.rd);
            chk("ram_addr", ram_addr, pend.addr);
            if (pend.rd) begin
                if (pend.port) q1.push_back('{cyc + 1, ref_mem[pend.addr]});
                else           q0.push_back('{cyc + 1, ref_mem[pend.addr]});
            end else begin
                chk("ram_wdata", ram_wdata, pend.wd);
                ref_mem[pend.addr] = pend.wd;
            end
        end else begin
            chk("ram_cs_idle", ram_cs, 0);
        end
        if (rst && prev_rst) begin
            chk("rst_ram_rw", ram_rw, 1);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
        end
        pend_v = eg0 || eg1;
        pend   = eg1 ? '{rd1, a1, d1, 1'b1} : '{rd0, a0, d0, 1'b0};
        if (rst || !r1 || eg1) lost = 0;
        else if (eg0)          lost++;
        last_g0  = eg0;
        last_g1  = eg1;
        prev_rst = rst;
    endtask

    always @(negedge clk) begin
        bit           e0, e1;
        logic [D-1:0] x0, x1;
        e0 = 0; e1 = 0; x0 = '0; x1 = '0;
        while (q0.size() > 0 && q0[0].due < cyc) begin
            chk("rvalid0_missing", 0, 1);
            void'(q0.pop_front());
        end
        while (q1.size() > 0 && q1[0].due < cyc) begin
            chk("rvalid1_missing", 0, 1);
            void'(q1.pop_front());
        end
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e0 = !reset; x0 = q0[0].data; void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e1 = !reset; x1 = q1[0].data; void'(q1.pop_front());
        end
        chk("rvalid0", rvalid0, e0);
        chk("rvalid1", rvalid1, e1);
        if (e0 && rvalid0) chk("rdata0", rdata0, x0);
        if (e1 && rvalid1) chk("rdata1", rdata1, x1);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, '0, '0, 0, 1, '0, '0);
    endtask

    initial begin
        bit           r0, rd0, r1, rd1, rst;
        logic [A-1:0] a0, a1;
        logic [D-1:0] d0, d1;
        for (int i = 0; i < (1 << A); i++) begin
            ram_mem[i] = D'(i) ^ 8'hA2;
            ref_mem[i] = D'(i) ^ 8'hA2;
        end
        reset = 1; req0 = 0; rw0 = 1; addr0 = '0; wdata0 = '0;
        req1 = 0; rw1 = 1; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 3; i++) drive(1, 0, 1, '0, '0, 0, 1, '0, '0);
        idle(2);
        // uncontested read of 0x005 (holds 0xA7)
        drive(0, 0, 1, '0, '0, 1, 1, 12'h005, '0);
        idle(3);
        // port 0 writes 0x3C to 0x010 while port 1 reads 0x010
        drive(0, 1, 0, 12'h010, 8'h3C, 1, 1, 12'h010, '0);
        drive(0, 0, 1, '0, '0, 1, 1, 12'h010, '0);
        idle(4);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, A'(i), '0, 0, 1, '0, '0);
        idle(3);
        // both ports held high to exercise the starvation guard
        n_g1_contested = 0;
        for (int i = 0; i < 20; i++)
            drive(0, 1, 1, A'(i), '0, 1, 1, A'(i + 100), '0);
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_gnt1_count", n_g1_contested, 4);
`else
        chk("starve_gnt1_count", n_g1_contested, 0);
`endif
        idle(3);
        // reset in the cycle after a read grant
        drive(0, 1, 1, 12'h007, '0, 0, 1, '0, '0);
        drive(1, 0, 1, '0, '0, 0, 1, '0, '0);
        drive(0, 1, 1, 12'h008, '0, 0, 1, '0, '0);
        idle(3);
        r0 = 0; rd0 = 1; a0 = '0; d0 = '0;
        r1 = 0; rd1 = 1; a1 = '0; d1 = '0;
        for (int i = 0; i < 600; i++) begin
            if (!(r0 && !last_g0)) begin
                r0  = ($urandom_range(0, 3) != 0);
                rd0 = $urandom_range(0, 1) == 1;
                a0  = A'($urandom_range(0, 15));
                d0  = D'($urandom);
            end
            if (!(r1 && !last_g1)) begin
                r1  = ($urandom_range(0, 2) != 0);
                rd1 = $urandom_range(0, 1) == 1;
                a1  = A'($urandom_range(0, 15));
                d1  = D'($urandom);
            end
            rst = ($urandom_range(0, 49) == 0);
            drive(rst, r0, rd0, a0, d0, r1, rd1, a1, d1);
        end
        idle(5);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
